// File: rtl/access_guard.sv
// access_guard: door controller sitting behind a 4-key password matcher.
//
// Counts key strobes into attempts, gives the matcher one cycle to settle,
// then either opens the door for OPEN_CYCLES or records a failure. After
// MAX_FAILS consecutive failures the keypad is locked out for LOCK_CYCLES.
// Once the door closes, relock is held until the matcher's unlock drops.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   key_stb    one-cycle pulse per key presented to the matcher
//   unlock     latched match level from the matcher
//   door_open  door actuator enable (registered)
//   relock     request to clear the matcher (registered)
//   locked_out keypad-disabled indicator (registered)
//   fail_cnt   consecutive-failure count (registered)
module access_guard #(
    parameter int unsigned OPEN_CYCLES   = 8,
    parameter int unsigned LOCK_CYCLES   = 16,
    parameter int unsigned MAX_FAILS     = 3,
    parameter int unsigned KEYS_PER_CODE = 4,
    parameter int unsigned TMR_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_stb,
    input  logic       unlock,
    output logic       door_open,
    output logic       relock,
    output logic       locked_out,
    output logic [2:0] fail_cnt
);

    localparam int unsigned EntryW = (KEYS_PER_CODE > 1) ? $clog2(KEYS_PER_CODE) : 1;

    localparam logic [TMR_W-1:0]  OpenLoad = TMR_W'(OPEN_CYCLES);
    localparam logic [TMR_W-1:0]  LockLoad = TMR_W'(LOCK_CYCLES);
    localparam logic [TMR_W-1:0]  TmrOne   = TMR_W'(1);
    localparam logic [EntryW-1:0] KeyLast  = EntryW'(KEYS_PER_CODE - 1);
    localparam logic [2:0]        FailMax  = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StOpen,
        StRelock,
        StLockout
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [EntryW-1:0] entry_q, entry_d;
    logic [2:0]        fail_q, fail_d;
    logic              door_q, relock_q, locked_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        entry_d = entry_q;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle: begin
                // A latched match wins over a coincident strobe.
                if (unlock) begin
                    state_d = StOpen;
                    timer_d = OpenLoad;
                    fail_d  = 3'd0;
                    entry_d = '0;
                end else if (key_stb) begin
                    if (entry_q == KeyLast) begin
                        entry_d = '0;
                        state_d = StCheck;
                    end else begin
                        entry_d = entry_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (unlock) begin
                    state_d = StOpen;
                    timer_d = OpenLoad;
                    fail_d  = 3'd0;
                end else begin
                    if (fail_q != FailMax) begin
                        fail_d = fail_q + 3'd1;
                    end
                    if (fail_q + 3'd1 >= FailMax) begin
                        state_d = StLockout;
                        timer_d = LockLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOpen: begin
                if (timer_q == TmrOne) begin
                    state_d = StRelock;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StRelock: begin
                // Wait for the matcher to actually clear before accepting keys.
                if (!unlock) begin
                    state_d = StIdle;
                    entry_d = '0;
                end
            end
            StLockout: begin
                if (timer_q == TmrOne) begin
                    state_d = StIdle;
                    timer_d = '0;
                    fail_d  = 3'd0;
                    entry_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
                entry_d = '0;
                fail_d  = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            entry_q  <= '0;
            fail_q   <= 3'd0;
            door_q   <= 1'b0;
            relock_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            entry_q  <= entry_d;
            fail_q   <= fail_d;
            door_q   <= (state_d == StOpen);
            relock_q <= (state_d == StRelock) || (state_d == StLockout);
            locked_q <= (state_d == StLockout);
        end
    end

    assign door_open  = door_q;
    assign relock     = relock_q;
    assign locked_out = locked_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_access_guard.sv
// Self-checking bench for access_guard: directed scenarios followed by a
// randomized phase, every cycle compared against a countdown-based model.
module tb_access_guard;

    localparam int OpenN = 8;
    localparam int LockN = 16;
    localparam int MaxF  = 3;
    localparam int Keys  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_stb;
    logic       unlock;
    logic       door_open;
    logic       relock;
    logic       locked_out;
    logic [2:0] fail_cnt;

    access_guard #(
        .OPEN_CYCLES  (OpenN),
        .LOCK_CYCLES  (LockN),
        .MAX_FAILS    (MaxF),
        .KEYS_PER_CODE(Keys),
        .TMR_W        (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .key_stb   (key_stb),
        .unlock    (unlock),
        .door_open (door_open),
        .relock    (relock),
        .locked_out(locked_out),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: remaining-time counters rather than a state machine.
    int m_keys      = 0;   // strobes collected toward the current attempt
    int m_open_left = 0;   // door cycles still to go
    int m_lock_left = 0;   // lockout cycles still to go
    int m_fails     = 0;
    bit m_pending   = 0;   // attempt complete, verdict due next cycle
    bit m_relock    = 0;   // door closed, waiting for matcher to clear

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input bit k, input bit u, input bit r);
        if (r) begin
            m_keys = 0; m_open_left = 0; m_lock_left = 0;
            m_fails = 0; m_pending = 0; m_relock = 0;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fails = 0;
                m_keys  = 0;
            end
        end else if (m_open_left > 0) begin
            m_open_left--;
            if (m_open_left == 0) m_relock = 1;
        end else if (m_relock) begin
            if (!u) begin
                m_relock = 0;
                m_keys   = 0;
            end
        end else if (m_pending) begin
            m_pending = 0;
            if (u) begin
                m_open_left = OpenN;
                m_fails     = 0;
            end else begin
                m_fails++;
                if (m_fails >= MaxF) m_lock_left = LockN;
            end
        end else if (u) begin
            m_open_left = OpenN;
            m_fails     = 0;
            m_keys      = 0;
        end else if (k) begin
            m_keys++;
            if (m_keys == Keys) begin
                m_keys    = 0;
                m_pending = 1;
            end
        end
    endtask

    // Apply inputs for one cycle, advance the model, compare after the edge.
    task automatic step(input bit k, input bit u, input bit r);
        key_stb = k;
        unlock  = u;
        rst     = r;
        @(posedge clk);
        cyc++;
        model_edge(k, u, r);
        #1;
        check_val("door_open",  door_open,  (m_open_left > 0));
        check_val("relock",     relock,     (m_relock || m_lock_left > 0));
        check_val("locked_out", locked_out, (m_lock_left > 0));
        check_val("fail_cnt",   fail_cnt,   m_fails);
    endtask

    // Four strobes with idle gaps, then the verdict cycle.
    task automatic attempt(input bit ok);
        for (int i = 0; i < Keys; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, ok, 1'b0);
    endtask

    // Keep the matcher latched for n cycles (random strobes must be ignored).
    task automatic hold(input int n, input bit u);
        for (int i = 0; i < n; i++) step($urandom_range(0, 1) == 1, u, 1'b0);
    endtask

    initial begin
        bit u_drv;
        key_stb = 1'b0;
        unlock  = 1'b0;
        rst     = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Success, unlock stays latched 3 cycles past the door timer.
        attempt(1'b1);
        hold(OpenN + 3, 1'b1);
        hold(4, 1'b0);

        // Two failures, then a success clears the count.
        attempt(1'b0);
        attempt(1'b0);
        attempt(1'b1);
        hold(OpenN, 1'b1);
        hold(3, 1'b0);

        // Three failures: lockout with strobes and unlock pulses ignored.
        attempt(1'b0);
        attempt(1'b0);
        attempt(1'b0);
        for (int i = 0; i < LockN + 2; i++) step($urandom_range(0, 1) == 1, i[0], 1'b0);
        step(1'b0, 1'b0, 1'b0);
        attempt(1'b0);

        // Reset in the middle of the door window.
        step(1'b0, 1'b0, 1'b1);
        attempt(1'b1);
        hold(2, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Reset in the middle of lockout.
        attempt(1'b0);
        attempt(1'b0);
        attempt(1'b0);
        hold(4, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        hold(3, 1'b0);

        // Random phase: sticky unlock level mimics a latching matcher.
        u_drv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (u_drv) u_drv = ($urandom_range(0, 3) != 0);
            else       u_drv = ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 2) == 0, u_drv, $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
